// File: rtl/sram_portb_arbiter_if.sv
// Port-B arbiter bundle: host write channel, TRNG sample strobe, ring config, SRAM port B, status.
// Latency: none (wires only).
// Backpressure: host waits for h_ack; TRNG has none (excess samples are dropped and counted).
interface sram_portb_arbiter_if #(
   parameter int ADDR_WD = 9,
   parameter int DATA_WD = 32
);
   // host write channel
   logic                   h_req;
   logic [ADDR_WD-1:0]     h_addr;
   logic [DATA_WD-1:0]     h_din;
   logic [DATA_WD/8-1:0]   h_mask;
   logic                   h_ack;
   // TRNG sample strobe
   logic                   trng_valid_i;
   logic [DATA_WD-1:0]     trng_data_i;
   // ring configuration
   logic                   cfg_en;
   logic [ADDR_WD-1:0]     cfg_base;
   logic [ADDR_WD-1:0]     cfg_len;
   logic                   cfg_clr;
   // SRAM port B
   logic                   sram_csb_b;
   logic                   sram_web_b;
   logic [DATA_WD/8-1:0]   sram_mask_b;
   logic [ADDR_WD-1:0]     sram_addr_b;
   logic [DATA_WD-1:0]     sram_din_b;
   // status
   logic [ADDR_WD-1:0]     wr_off_o;
   logic                   overflow_o;
   logic [7:0]             drop_cnt_o;
   logic                   wrap_irq_o;

   modport slave (
      input  h_req, h_addr, h_din, h_mask, trng_valid_i, trng_data_i,
             cfg_en, cfg_base, cfg_len, cfg_clr,
      output h_ack, sram_csb_b, sram_web_b, sram_mask_b, sram_addr_b, sram_din_b,
             wr_off_o, overflow_o, drop_cnt_o, wrap_irq_o
   );

   modport master (
      output h_req, h_addr, h_din, h_mask, trng_valid_i, trng_data_i,
             cfg_en, cfg_base, cfg_len, cfg_clr,
      input  h_ack, sram_csb_b, sram_web_b, sram_mask_b, sram_addr_b, sram_din_b,
             wr_off_o, overflow_o, drop_cnt_o, wrap_irq_o
   );
endinterface

// File: rtl/sram_portb_arbiter.sv
// Round-robin arbiter sharing SRAM port B between a host writer and a TRNG ring-buffer writer.
// Latency: grant sampled in IDLE, write issued the next cycle (WRITE), so at most 2 cycles per write.
// Backpressure: host holds h_req until h_ack; a TRNG sample arriving with a full hold register is dropped.
module sram_portb_arbiter #(
   parameter int SRAM_ADDR_WD = 9,
   parameter int SRAM_DATA_WD = 32
) (
   input logic                  wb_clk_i,
   input logic                  rst_ni,
   sram_portb_arbiter_if.slave  bus
);
   localparam int MASK_WD = SRAM_DATA_WD / 8;
   localparam logic [SRAM_ADDR_WD-1:0] ADDR_ONE = 1;
   localparam logic GNT_HOST = 1'b0;
   localparam logic GNT_TRNG = 1'b1;

   typedef enum logic {ST_IDLE = 1'b0, ST_WRITE = 1'b1} state_t;

   state_t                    state_q, state_d;
   logic                      gnt_q, gnt_d;            // owner of the current WRITE
   logic                      last_gnt_q, last_gnt_d;  // round-robin pointer
   logic                      csb_q, csb_d;
   logic                      web_q, web_d;
   logic [MASK_WD-1:0]        mask_q, mask_d;
   logic [SRAM_ADDR_WD-1:0]   addr_q, addr_d;
   logic [SRAM_DATA_WD-1:0]   din_q, din_d;
   logic                      ack_q, ack_d;
   logic                      wrap_q, wrap_d;
   logic [SRAM_ADDR_WD-1:0]   wr_off_q, wr_off_d;
   logic                      hold_valid_q, hold_valid_d;
   logic [SRAM_DATA_WD-1:0]   hold_data_q, hold_data_d;
   logic                      overflow_q, overflow_d;
   logic [7:0]                drop_cnt_q, drop_cnt_d;

   logic en_ok, consume, trng_elig, host_win, trng_win, drop;

   // Request qualification and round-robin decision, only meaningful in IDLE
   always_comb begin
      en_ok     = bus.cfg_en && (bus.cfg_len != '0);
      consume   = (state_q == ST_WRITE) && (gnt_q == GNT_TRNG);
      trng_elig = hold_valid_q && en_ok;
      host_win  = (state_q == ST_IDLE) && bus.h_req && (!trng_elig || (last_gnt_q == GNT_TRNG));
      trng_win  = (state_q == ST_IDLE) && trng_elig && !host_win;
      drop      = en_ok && bus.trng_valid_i && hold_valid_q && !consume;
   end

   // FSM state register
   always_ff @(posedge wb_clk_i) begin
      if (!rst_ni) state_q <= ST_IDLE;
      else         state_q <= state_d;
   end

   // FSM next state: a grant moves to WRITE, WRITE always returns to IDLE
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (host_win || trng_win) state_d = ST_WRITE;
         ST_WRITE: state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // FSM outputs: load port-B registers for the winner, advance the ring offset on TRNG grants
   always_comb begin
      csb_d      = 1'b1;
      web_d      = 1'b1;
      mask_d     = mask_q;
      addr_d     = addr_q;
      din_d      = din_q;
      ack_d      = 1'b0;
      wrap_d     = 1'b0;
      gnt_d      = gnt_q;
      last_gnt_d = last_gnt_q;
      wr_off_d   = wr_off_q;
      if (host_win) begin
         csb_d      = 1'b0;
         web_d      = 1'b0;
         addr_d     = bus.h_addr;
         din_d      = bus.h_din;
         mask_d     = bus.h_mask;
         ack_d      = 1'b1;
         gnt_d      = GNT_HOST;
         last_gnt_d = GNT_HOST;
      end else if (trng_win) begin
         csb_d      = 1'b0;
         web_d      = 1'b0;
         addr_d     = bus.cfg_base + wr_off_q;
         din_d      = hold_data_q;
         mask_d     = '1;
         gnt_d      = GNT_TRNG;
         last_gnt_d = GNT_TRNG;
         // wrap only on exact equality; an offset already past the length keeps counting
         if (wr_off_q == bus.cfg_len - ADDR_ONE) begin
            wr_off_d = '0;
            wrap_d   = 1'b1;
         end else begin
            wr_off_d = wr_off_q + ADDR_ONE;
         end
      end
      if (!en_ok) wr_off_d = '0;
   end

   // Sample hold register and drop accounting; a drop outranks a simultaneous clear
   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_data_d  = hold_data_q;
      overflow_d   = overflow_q;
      drop_cnt_d   = drop_cnt_q;
      if (!en_ok) begin
         hold_valid_d = 1'b0;
      end else if (bus.trng_valid_i && (!hold_valid_q || consume)) begin
         hold_valid_d = 1'b1;
         hold_data_d  = bus.trng_data_i;
      end else if (consume) begin
         hold_valid_d = 1'b0;
      end
      if (drop) begin
         overflow_d = 1'b1;
         if (bus.cfg_clr)                drop_cnt_d = 8'd1;
         else if (drop_cnt_q != 8'hFF)   drop_cnt_d = drop_cnt_q + 8'd1;
      end else if (bus.cfg_clr) begin
         overflow_d = 1'b0;
         drop_cnt_d = 8'd0;
      end
   end

   // Datapath and status registers with synchronous reset
   always_ff @(posedge wb_clk_i) begin
      if (!rst_ni) begin
         gnt_q        <= GNT_HOST;
         last_gnt_q   <= GNT_TRNG;
         csb_q        <= 1'b1;
         web_q        <= 1'b1;
         mask_q       <= '0;
         addr_q       <= '0;
         din_q        <= '0;
         ack_q        <= 1'b0;
         wrap_q       <= 1'b0;
         wr_off_q     <= '0;
         hold_valid_q <= 1'b0;
         hold_data_q  <= '0;
         overflow_q   <= 1'b0;
         drop_cnt_q   <= 8'd0;
      end else begin
         gnt_q        <= gnt_d;
         last_gnt_q   <= last_gnt_d;
         csb_q        <= csb_d;
         web_q        <= web_d;
         mask_q       <= mask_d;
         addr_q       <= addr_d;
         din_q        <= din_d;
         ack_q        <= ack_d;
         wrap_q       <= wrap_d;
         wr_off_q     <= wr_off_d;
         hold_valid_q <= hold_valid_d;
         hold_data_q  <= hold_data_d;
         overflow_q   <= overflow_d;
         drop_cnt_q   <= drop_cnt_d;
      end
   end

   assign bus.sram_csb_b  = csb_q;
   assign bus.sram_web_b  = web_q;
   assign bus.sram_mask_b = mask_q;
   assign bus.sram_addr_b = addr_q;
   assign bus.sram_din_b  = din_q;
   assign bus.h_ack       = ack_q;
   assign bus.wrap_irq_o  = wrap_q;
   assign bus.wr_off_o    = wr_off_q;
   assign bus.overflow_o  = overflow_q;
   assign bus.drop_cnt_o  = drop_cnt_q;
endmodule

// File: doc/sram_portb_arbiter.md
SRAM_PORTB_ARBITER -- requirements
Module: sram_portb_arbiter

Interface
REQ-001 SHALL have parameter SRAM_ADDR_WD, default 9, SRAM word-address width.
REQ-002 SHALL have parameter SRAM_DATA_WD, default 32, SRAM data width; mask width is SRAM_DATA_WD/8.
REQ-003 SHALL have port wb_clk_i, input, 1: single clock; all logic rising-edge.
REQ-004 SHALL have port rst_ni, input, 1: reset, synchronous, active-low.
REQ-005 SHALL have host ports h_req (in, 1, level write request), h_addr (in, ADDR_WD), h_din (in, DATA_WD), h_mask (in, DATA_WD/8) and h_ack (out, 1, write-done pulse).
REQ-006 SHALL have TRNG ports trng_valid_i (in, 1, one-cycle sample strobe) and trng_data_i (in, DATA_WD).
REQ-007 SHALL have config ports cfg_en (in, 1), cfg_base (in, ADDR_WD, ring start), cfg_len (in, ADDR_WD, ring length in words) and cfg_clr (in, 1, status-clear pulse).
REQ-008 SHALL have SRAM port-B outputs sram_csb_b (1, active-low), sram_web_b (1, active-low write), sram_mask_b (DATA_WD/8), sram_addr_b (ADDR_WD) and sram_din_b (DATA_WD), all driven from registers.
REQ-009 SHALL have status outputs wr_off_o (ADDR_WD, ring offset of next sample), overflow_o (1, sticky), drop_cnt_o (8, dropped samples) and wrap_irq_o (1, pulse).

Function
REQ-010 SHALL implement two states: IDLE and WRITE; each WRITE lasts exactly one cycle and is always followed by IDLE, so one write takes at most 2 cycles.
REQ-011 In IDLE, requests SHALL be sampled; eligible requesters are host (h_req=1) and TRNG (hold_valid=1).
REQ-012 A single eligible requester SHALL be granted; with both eligible, the one not granted last (last_gnt) SHALL win (round-robin).
REQ-013 On a grant, the next cycle SHALL be WRITE with sram_csb_b=0 and sram_web_b=0, carrying the winner's address, data and mask; in all other cycles sram_csb_b=1 and sram_web_b=1.
REQ-014 A host grant SHALL drive h_addr, h_din and h_mask, sampled at the IDLE edge, and SHALL pulse h_ack=1 during that WRITE cycle only.
REQ-015 The host SHALL deassert h_req or present the next request by the edge ending WRITE; requests are ignored in WRITE.
REQ-016 A TRNG grant SHALL drive addr = (cfg_base + wr_off) mod 2^ADDR_WD, data = hold register and mask = all ones.
REQ-017 A TRNG grant SHALL clear hold_valid at the end of WRITE.
REQ-018 A TRNG write SHALL increment wr_off; when wr_off == cfg_len-1 it SHALL wrap to 0 and pulse wrap_irq_o for 1 cycle, coincident with WRITE.
REQ-019 Sample capture SHALL occur when trng_valid_i=1, cfg_en=1 and cfg_len!=0: if hold_valid=0, or if the hold is being consumed in the same cycle (WRITE of TRNG), the hold SHALL load trng_data_i and set hold_valid=1.
REQ-020 If a sample arrives while the hold is full and not being consumed, it SHALL be dropped: overflow_o is set and drop_cnt_o increments, saturating at 255.
REQ-021 With cfg_en=0 or cfg_len=0, samples SHALL be ignored, hold_valid and wr_off SHALL be held at 0, and host traffic SHALL be unaffected; a TRNG WRITE already in progress SHALL complete.
REQ-022 cfg_clr=1 SHALL zero overflow_o and drop_cnt_o next edge; a simultaneous drop SHALL take priority, leaving overflow_o=1 and drop_cnt_o=1.
REQ-023 Config changes while enabled SHALL take effect on the next TRNG grant; the block SHALL not check wr_off >= cfg_len, and wrap is only on equality.

Reset
REQ-024 While rst_ni=0 at an edge: state=IDLE, sram_csb_b=1, sram_web_b=1, sram_mask_b=0, sram_addr_b=0, sram_din_b=0, h_ack=0, hold_valid=0, wr_off_o=0, overflow_o=0, drop_cnt_o=0, wrap_irq_o=0, last_gnt=TRNG (host wins the first tie).
REQ-025 Reset asserted during WRITE SHALL abort it: csb_b=1 and no h_ack on the following cycle; a pending hold sample is lost.

Verification
REQ-026 Reset release, h_req with addr 0x010, data 0xDEADBEEF, mask 0xF -> one cycle later csb_b=0, web_b=0, addr 0x010, din 0xDEADBEEF, h_ack=1 for exactly 1 cycle.
REQ-027 cfg_en=1, base 0x100, len 4; six samples spaced 3 cycles apart -> writes at 0x100, 0x101, 0x102, 0x103, 0x100, 0x101; wrap_irq_o pulses once, on the 0x103 write.
REQ-028 h_req held high with a sample pending in the same cycle after reset -> host written first, then TRNG; with both continuously requesting, grants alternate H, T, H, T.
REQ-029 Hold full, host holding the port for 2 grants, 3 further samples arrive -> overflow_o=1, drop_cnt_o=3; cfg_clr -> both 0; 260 drops -> drop_cnt_o=255.
REQ-030 rst_ni=0 in WRITE cycle -> next cycle csb_b=1, h_ack=0, all status 0; cfg_en=0 with samples -> no port-B activity.
